// File: rtl/dcmac_pkg.sv
// Shared constants and types for the DCMAC RX packet buffer.
// Segment geometry, write-FSM state encoding and a saturating counter helper.
package dcmac_pkg;

  localparam int unsigned SEG_COUNT  = 4;
  localparam int unsigned SEG_DATA_W = 128;
  localparam int unsigned SEG_USER_W = 5;
  localparam int unsigned BEAT_BYTES = 64;
  localparam int unsigned DATA_W     = SEG_COUNT * SEG_DATA_W;
  localparam int unsigned USER_W     = SEG_COUNT * SEG_USER_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    DROP  = 2'd2
  } wr_state_e;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + {31'd0, inc};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/dcmac_rx_sdp_ram.sv
// Simple dual-port RAM with one write port and a registered read port.
// The read register resets to zero so the downstream output is clean out of reset.
module dcmac_rx_sdp_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 533
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/dcmac_rx_packet_buffer.sv
// Store-and-forward RX packet buffer: packets are released only once complete and
// error-free; bad packets are discarded by rewinding the speculative write pointer.
module dcmac_rx_packet_buffer
  import dcmac_pkg::*;
#(
  parameter int unsigned DEPTH           = 512,
  parameter int unsigned MAX_PACKET_SIZE = 16384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              s_axis_tsop,
  input  logic              s_axis_tlast,
  input  logic              s_axis_terr,
  input  logic              s_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [31:0]       pkt_ok_count,
  output logic [31:0]       pkt_drop_count
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned PW        = AW + 1;
  localparam int unsigned MAX_BEATS = MAX_PACKET_SIZE / BEAT_BYTES;
  localparam int unsigned CW        = $clog2(MAX_BEATS + 2);
  localparam int unsigned MW        = 1 + USER_W + DATA_W;

  wr_state_e       r_state, w_state_nxt;
  logic [PW-1:0]   r_wr_ptr, r_cmt_ptr, r_rd_ptr;
  logic [PW-1:0]   w_wr_nxt, w_cmt_nxt, w_base;
  logic [CW-1:0]   r_beat_cnt, w_cnt_nxt;
  logic [31:0]     r_ok_cnt, r_drop_cnt;
  logic            r_tvalid;
  logic            w_trunc, w_space, w_we, w_ok_inc, w_load;
  logic [1:0]      w_drop_inc;
  logic [MW-1:0]   w_rdata;

  // A sop in STORE rewinds first, so both the space check and the write use cmt_ptr.
  assign w_trunc = (r_state == STORE) && s_axis_tvalid && s_axis_tsop;
  assign w_base  = w_trunc ? r_cmt_ptr : r_wr_ptr;
  assign w_space = (w_base - r_rd_ptr) != PW'(DEPTH);

  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = r_wr_ptr;
    w_cmt_nxt   = r_cmt_ptr;
    w_cnt_nxt   = r_beat_cnt;
    w_we        = 1'b0;
    w_ok_inc    = 1'b0;
    w_drop_inc  = '0;
    if (s_axis_tvalid) begin
      if (s_axis_tsop) begin
        w_drop_inc = {1'b0, w_trunc};
        if (!w_space) begin
          w_drop_inc  = w_drop_inc + 2'd1;
          w_wr_nxt    = r_cmt_ptr;
          w_state_nxt = s_axis_tlast ? IDLE : DROP;
        end else begin
          w_we      = 1'b1;
          w_cnt_nxt = CW'(1);
          if (s_axis_tlast) begin
            w_state_nxt = IDLE;
            if (s_axis_terr) begin
              w_drop_inc = w_drop_inc + 2'd1;
              w_wr_nxt   = r_cmt_ptr;
            end else begin
              w_ok_inc  = 1'b1;
              w_wr_nxt  = w_base + PW'(1);
              w_cmt_nxt = w_base + PW'(1);
            end
          end else begin
            w_wr_nxt    = w_base + PW'(1);
            w_state_nxt = STORE;
          end
        end
      end else begin
        case (r_state)
          STORE: begin
            if (r_beat_cnt != CW'(MAX_BEATS + 1)) w_cnt_nxt = r_beat_cnt + CW'(1);
            if (!w_space || (r_beat_cnt >= CW'(MAX_BEATS))) begin
              w_drop_inc  = 2'd1;
              w_wr_nxt    = r_cmt_ptr;
              w_state_nxt = s_axis_tlast ? IDLE : DROP;
            end else begin
              w_we     = 1'b1;
              w_wr_nxt = r_wr_ptr + PW'(1);
              if (s_axis_tlast) begin
                w_state_nxt = IDLE;
                if (s_axis_terr) begin
                  w_drop_inc = 2'd1;
                  w_wr_nxt   = r_cmt_ptr;
                end else begin
                  w_ok_inc  = 1'b1;
                  w_cmt_nxt = r_wr_ptr + PW'(1);
                end
              end
            end
          end
          DROP:    if (s_axis_tlast) w_state_nxt = IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_cmt_ptr  <= '0;
      r_beat_cnt <= '0;
      r_ok_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_nxt;
      r_cmt_ptr  <= w_cmt_nxt;
      r_beat_cnt <= w_cnt_nxt;
      r_ok_cnt   <= sat_add32(r_ok_cnt, {1'b0, w_ok_inc});
      r_drop_cnt <= sat_add32(r_drop_cnt, w_drop_inc);
    end
  end

  // Reads compare against the registered commit pointer, never the speculative one.
  assign w_load = (r_rd_ptr != r_cmt_ptr) && (!r_tvalid || m_axis_tready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_tvalid <= 1'b0;
    end else if (w_load) begin
      r_rd_ptr <= r_rd_ptr + PW'(1);
      r_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  dcmac_rx_sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (MW)
  ) u_ram (
    .clk     (clk),
    .rst     (reset),
    .i_we    (w_we),
    .i_waddr (w_base[AW-1:0]),
    .i_wdata ({s_axis_tlast, s_axis_tuser, s_axis_tdata}),
    .i_re    (w_load),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = w_rdata;
  assign m_axis_tvalid  = r_tvalid;
  assign pkt_ok_count   = r_ok_cnt;
  assign pkt_drop_count = r_drop_cnt;

endmodule

// File: tb/tb_dcmac_rx_packet_buffer.sv
// Directed bench for dcmac_rx_packet_buffer: three instances (default, DEPTH=16,
// MAX_PACKET_SIZE=1024) share one input stream; a selector picks which output is captured.
module tb_dcmac_rx_packet_buffer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] s_tdata = '0;
  logic [19:0]  s_tuser = '0;
  logic         s_tsop = 1'b0, s_tlast = 1'b0, s_terr = 1'b0, s_tvalid = 1'b0;
  logic         tready = 1'b0;

  logic [511:0] m_tdata  [3];
  logic [19:0]  m_tuser  [3];
  logic         m_tlast  [3];
  logic         m_tvalid [3];
  logic [31:0]  ok_cnt   [3];
  logic [31:0]  drop_cnt [3];

  int checks = 0;
  int failures = 0;
  int unsigned sel = 0;

  logic [511:0] got_dat[$], exp_dat[$];
  logic [19:0]  got_usr[$], exp_usr[$];
  logic         got_lst[$], exp_lst[$];

  always #5 clk = ~clk;

  dcmac_rx_packet_buffer u_dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tsop(s_tsop),
    .s_axis_tlast(s_tlast), .s_axis_terr(s_terr), .s_axis_tvalid(s_tvalid),
    .m_axis_tdata(m_tdata[0]), .m_axis_tuser(m_tuser[0]), .m_axis_tlast(m_tlast[0]),
    .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(tready),
    .pkt_ok_count(ok_cnt[0]), .pkt_drop_count(drop_cnt[0])
  );

  dcmac_rx_packet_buffer #(.DEPTH(16)) u_ovf (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tsop(s_tsop),
    .s_axis_tlast(s_tlast), .s_axis_terr(s_terr), .s_axis_tvalid(s_tvalid),
    .m_axis_tdata(m_tdata[1]), .m_axis_tuser(m_tuser[1]), .m_axis_tlast(m_tlast[1]),
    .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(tready),
    .pkt_ok_count(ok_cnt[1]), .pkt_drop_count(drop_cnt[1])
  );

  dcmac_rx_packet_buffer #(.MAX_PACKET_SIZE(1024)) u_osz (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tsop(s_tsop),
    .s_axis_tlast(s_tlast), .s_axis_terr(s_terr), .s_axis_tvalid(s_tvalid),
    .m_axis_tdata(m_tdata[2]), .m_axis_tuser(m_tuser[2]), .m_axis_tlast(m_tlast[2]),
    .m_axis_tvalid(m_tvalid[2]), .m_axis_tready(tready),
    .pkt_ok_count(ok_cnt[2]), .pkt_drop_count(drop_cnt[2])
  );

  always @(negedge clk) begin
    if (m_tvalid[sel] && tready) begin
      got_dat.push_back(m_tdata[sel]);
      got_usr.push_back(m_tuser[sel]);
      got_lst.push_back(m_tlast[sel]);
    end
  end

  function automatic logic [511:0] gen_data(input int unsigned p, input int unsigned b);
    logic [511:0] d;
    for (int unsigned i = 0; i < 16; i++)
      d[32*i +: 32] = {p[15:0], b[15:0]} ^ (i * 32'h9E3779B9);
    return d;
  endfunction

  function automatic logic [19:0] gen_user(input int unsigned p, input int unsigned b);
    return {p[9:0], b[9:0]} ^ 20'h5A5A5;
  endfunction

  task automatic start_test(input int unsigned which);
    s_tvalid = 1'b0; s_tsop = 1'b0; s_tlast = 1'b0; s_terr = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sel = which;
    got_dat.delete(); got_usr.delete(); got_lst.delete();
    exp_dat.delete(); exp_usr.delete(); exp_lst.delete();
  endtask

  task automatic send_pkt(input int unsigned p, input int unsigned n, input bit last,
                          input bit err, input bit expect_out);
    for (int unsigned b = 0; b < n; b++) begin
      s_tvalid = 1'b1;
      s_tsop   = (b == 0);
      s_tlast  = last && (b == n - 1);
      s_terr   = err && (b == n - 1);
      s_tdata  = gen_data(p, b);
      s_tuser  = gen_user(p, b);
      if (expect_out) begin
        exp_dat.push_back(s_tdata);
        exp_usr.push_back(s_tuser);
        exp_lst.push_back(s_tlast);
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0; s_tsop = 1'b0; s_tlast = 1'b0; s_terr = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned n, input int unsigned budget);
    int unsigned c = 0;
    while (got_dat.size() < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int unsigned k = 0; k < 3; k++) begin
      checks++;
      if ({m_tvalid[k], m_tlast[k], m_tuser[k], m_tdata[k], ok_cnt[k], drop_cnt[k]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d got valid=%b last=%b user=%h ok=%0d drop=%0d required all zero",
                 k, m_tvalid[k], m_tlast[k], m_tuser[k], ok_cnt[k], drop_cnt[k]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_good_packets;
    int unsigned n, nl;
    start_test(0);
    tready = 1'b1;
    send_pkt(1, 4, 1, 0, 1);
    send_pkt(2, 1, 1, 0, 1);
    send_pkt(3, 256, 1, 0, 1);
    wait_drain(261, 2000);
    checks++;
    if (got_dat.size() !== 261) begin
      failures++;
      $display("FAIL good_beat_count got=%0d required=261", got_dat.size());
    end
    n = got_dat.size(); if (exp_dat.size() < n) n = exp_dat.size();
    for (int unsigned i = 0; i < n; i++) begin
      checks++;
      if ({got_lst[i], got_usr[i], got_dat[i]} !== {exp_lst[i], exp_usr[i], exp_dat[i]}) begin
        failures++;
        $display("FAIL good_beat[%0d] got last=%b user=%h data[31:0]=%h required last=%b user=%h data[31:0]=%h",
                 i, got_lst[i], got_usr[i], got_dat[i][31:0], exp_lst[i], exp_usr[i], exp_dat[i][31:0]);
      end
    end
    nl = 0;
    for (int unsigned i = 0; i < got_lst.size(); i++) nl += int'(got_lst[i]);
    checks++;
    if (nl !== 3) begin
      failures++;
      $display("FAIL good_tlast_count got=%0d required=3", nl);
    end
    checks++;
    if (ok_cnt[0] !== 32'd3 || drop_cnt[0] !== 32'd0) begin
      failures++;
      $display("FAIL good_counters got ok=%0d drop=%0d required ok=3 drop=0", ok_cnt[0], drop_cnt[0]);
    end
  endtask

  task automatic test_latency;
    start_test(0);
    tready = 1'b1;
    send_pkt(5, 1, 1, 0, 1);
    checks++;
    if (m_tvalid[0] !== 1'b0) begin
      failures++;
      $display("FAIL latency_commit_edge got valid=%b required 0", m_tvalid[0]);
    end
    @(posedge clk); #1;
    checks++;
    if ({m_tvalid[0], m_tlast[0], m_tuser[0], m_tdata[0]} !== {1'b1, 1'b1, gen_user(5, 0), gen_data(5, 0)}) begin
      failures++;
      $display("FAIL latency_next_edge got valid=%b last=%b user=%h required valid=1 last=1 user=%h",
               m_tvalid[0], m_tlast[0], m_tuser[0], gen_user(5, 0));
    end
    @(posedge clk); #1;
    checks++;
    if (m_tvalid[0] !== 1'b0) begin
      failures++;
      $display("FAIL latency_valid_clear got valid=%b required 0", m_tvalid[0]);
    end
  endtask

  task automatic test_error_packet;
    int unsigned n;
    start_test(0);
    tready = 1'b1;
    send_pkt(10, 10, 1, 1, 0);
    checks++;
    if (u_dut.r_cmt_ptr !== '0) begin
      failures++;
      $display("FAIL error_cmt_ptr got=%0d required=0", u_dut.r_cmt_ptr);
    end
    send_pkt(11, 2, 1, 0, 1);
    wait_drain(2, 100);
    checks++;
    if (got_dat.size() !== 2) begin
      failures++;
      $display("FAIL error_beat_count got=%0d required=2", got_dat.size());
    end
    n = got_dat.size(); if (exp_dat.size() < n) n = exp_dat.size();
    for (int unsigned i = 0; i < n; i++) begin
      checks++;
      if ({got_lst[i], got_usr[i], got_dat[i]} !== {exp_lst[i], exp_usr[i], exp_dat[i]}) begin
        failures++;
        $display("FAIL error_beat[%0d] got last=%b user=%h required last=%b user=%h",
                 i, got_lst[i], got_usr[i], exp_lst[i], exp_usr[i]);
      end
    end
    checks++;
    if (ok_cnt[0] !== 32'd1 || drop_cnt[0] !== 32'd1) begin
      failures++;
      $display("FAIL error_counters got ok=%0d drop=%0d required ok=1 drop=1", ok_cnt[0], drop_cnt[0]);
    end
  endtask

  task automatic test_truncation;
    int unsigned n;
    start_test(0);
    tready = 1'b1;
    send_pkt(30, 5, 0, 0, 0);
    send_pkt(31, 3, 1, 0, 1);
    wait_drain(3, 100);
    checks++;
    if (got_dat.size() !== 3) begin
      failures++;
      $display("FAIL trunc_beat_count got=%0d required=3", got_dat.size());
    end
    n = got_dat.size(); if (exp_dat.size() < n) n = exp_dat.size();
    for (int unsigned i = 0; i < n; i++) begin
      checks++;
      if ({got_lst[i], got_usr[i], got_dat[i]} !== {exp_lst[i], exp_usr[i], exp_dat[i]}) begin
        failures++;
        $display("FAIL trunc_beat[%0d] got last=%b user=%h required last=%b user=%h",
                 i, got_lst[i], got_usr[i], exp_lst[i], exp_usr[i]);
      end
    end
    checks++;
    if (ok_cnt[0] !== 32'd1 || drop_cnt[0] !== 32'd1) begin
      failures++;
      $display("FAIL trunc_counters got ok=%0d drop=%0d required ok=1 drop=1", ok_cnt[0], drop_cnt[0]);
    end
  endtask

  task automatic test_overflow;
    int unsigned n;
    start_test(1);
    tready = 1'b0;
    send_pkt(40, 12, 1, 0, 1);
    send_pkt(41, 10, 1, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ok_cnt[1] !== 32'd1 || drop_cnt[1] !== 32'd1) begin
      failures++;
      $display("FAIL ovf_counters got ok=%0d drop=%0d required ok=1 drop=1", ok_cnt[1], drop_cnt[1]);
    end
    tready = 1'b1;
    wait_drain(12, 200);
    checks++;
    if (got_dat.size() !== 12) begin
      failures++;
      $display("FAIL ovf_beat_count got=%0d required=12", got_dat.size());
    end
    n = got_dat.size(); if (exp_dat.size() < n) n = exp_dat.size();
    for (int unsigned i = 0; i < n; i++) begin
      checks++;
      if ({got_lst[i], got_usr[i], got_dat[i]} !== {exp_lst[i], exp_usr[i], exp_dat[i]}) begin
        failures++;
        $display("FAIL ovf_beat[%0d] got last=%b user=%h required last=%b user=%h",
                 i, got_lst[i], got_usr[i], exp_lst[i], exp_usr[i]);
      end
    end
  endtask

  task automatic test_oversize;
    int unsigned n;
    start_test(2);
    tready = 1'b1;
    send_pkt(50, 17, 1, 0, 0);
    send_pkt(51, 16, 1, 0, 1);
    wait_drain(16, 200);
    checks++;
    if (got_dat.size() !== 16) begin
      failures++;
      $display("FAIL osz_beat_count got=%0d required=16", got_dat.size());
    end
    n = got_dat.size(); if (exp_dat.size() < n) n = exp_dat.size();
    for (int unsigned i = 0; i < n; i++) begin
      checks++;
      if ({got_lst[i], got_usr[i], got_dat[i]} !== {exp_lst[i], exp_usr[i], exp_dat[i]}) begin
        failures++;
        $display("FAIL osz_beat[%0d] got last=%b user=%h required last=%b user=%h",
                 i, got_lst[i], got_usr[i], exp_lst[i], exp_usr[i]);
      end
    end
    checks++;
    if (ok_cnt[2] !== 32'd1 || drop_cnt[2] !== 32'd1) begin
      failures++;
      $display("FAIL osz_counters got ok=%0d drop=%0d required ok=1 drop=1", ok_cnt[2], drop_cnt[2]);
    end
  endtask

  task automatic test_reset_mid_packet;
    int unsigned n;
    start_test(0);
    tready = 1'b0;
    send_pkt(20, 2, 1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_tvalid[0], m_tlast[0], m_tdata[0]} !== {1'b1, 1'b0, gen_data(20, 0)}) begin
      failures++;
      $display("FAIL hold_first got valid=%b last=%b data[31:0]=%h required valid=1 last=0 data[31:0]=%h",
               m_tvalid[0], m_tlast[0], m_tdata[0][31:0], gen_data(20, 0) & 512'hFFFFFFFF);
    end
    send_pkt(22, 3, 0, 0, 0);
    checks++;
    if ({m_tvalid[0], m_tdata[0]} !== {1'b1, gen_data(20, 0)}) begin
      failures++;
      $display("FAIL hold_stable got valid=%b data[31:0]=%h required valid=1 data[31:0]=%h",
               m_tvalid[0], m_tdata[0][31:0], gen_data(20, 0) & 512'hFFFFFFFF);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({m_tvalid[0], m_tlast[0], m_tuser[0], m_tdata[0], ok_cnt[0], drop_cnt[0]} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got valid=%b last=%b user=%h ok=%0d drop=%0d required all zero",
               m_tvalid[0], m_tlast[0], m_tuser[0], ok_cnt[0], drop_cnt[0]);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    got_dat.delete(); got_usr.delete(); got_lst.delete();
    tready = 1'b1;
    send_pkt(21, 2, 1, 0, 1);
    wait_drain(2, 100);
    checks++;
    if (got_dat.size() !== 2) begin
      failures++;
      $display("FAIL reset_mid_beat_count got=%0d required=2", got_dat.size());
    end
    n = got_dat.size(); if (exp_dat.size() < n) n = exp_dat.size();
    for (int unsigned i = 0; i < n; i++) begin
      checks++;
      if ({got_lst[i], got_usr[i], got_dat[i]} !== {exp_lst[i], exp_usr[i], exp_dat[i]}) begin
        failures++;
        $display("FAIL reset_mid_beat[%0d] got last=%b user=%h required last=%b user=%h",
                 i, got_lst[i], got_usr[i], exp_lst[i], exp_usr[i]);
      end
    end
    checks++;
    if (ok_cnt[0] !== 32'd1 || drop_cnt[0] !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_counters got ok=%0d drop=%0d required ok=1 drop=0", ok_cnt[0], drop_cnt[0]);
    end
  endtask

  initial begin
    test_reset();
    test_good_packets();
    test_latency();
    test_error_packet();
    test_truncation();
    test_overflow();
    test_oversize();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
